// File: rtl/rcpu_uart_io.sv
// UART peripheral on the rcpu IO bus: DATA/STATUS/BAUD registers, TX and RX byte
// FIFOs, and 8N1 serialiser/deserialiser running off a programmable baud divisor.
module rcpu_uart_io #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 104
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_read_enable,
   input  logic        io_write_enable,
   input  logic [15:0] io_address,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [15:0] ADDR_DATA   = 16'h0000;
   localparam logic [15:0] ADDR_STATUS = 16'h0004;
   localparam logic [15:0] ADDR_BAUD   = 16'h0008;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   logic sel_data, sel_status, sel_baud;
   logic tx_push_req, rx_pop_req, status_rd;

   assign sel_data    = (io_address == ADDR_DATA);
   assign sel_status  = (io_address == ADDR_STATUS);
   assign sel_baud    = (io_address == ADDR_BAUD);
   assign tx_push_req = io_write_enable && sel_data;
   assign rx_pop_req  = io_read_enable && sel_data;
   assign status_rd   = io_read_enable && sel_status;

   logic [15:0] baud;
   logic        tx_overflow, rx_overflow, frame_err;

   // ---------------- TX FIFO ----------------
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [CW-1:0] tx_count;
   logic          tx_full, tx_empty, tx_push, tx_pop;
   tx_state_t     tx_state, tx_state_nx;

   assign tx_full  = (tx_count == FULL_CNT);
   assign tx_empty = (tx_count == '0);
   assign tx_push  = tx_push_req && !tx_full;
   assign tx_pop   = (tx_state == TX_IDLE) && !tx_empty;

   // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define its contents.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= io_write_data[7:0];
   end

   // NOTE: all sequential state is updated with non-blocking assignments.
   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      end
   end

   // ---------------- TX FSM ----------------
   logic [15:0] tx_cnt, tx_cnt_nx, tx_div, tx_div_nx;
   logic [7:0]  tx_shift, tx_shift_nx;
   logic [2:0]  tx_bit, tx_bit_nx;
   logic        tx_line_nx, tx_last, tx_idle;

   assign tx_last = (tx_cnt == tx_div - 16'd1);
   assign tx_idle = tx_empty && (tx_state == TX_IDLE);

   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= 16'(DIV_RESET);
         tx_shift <= '0;
         tx_bit   <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_div   <= tx_div_nx;
         tx_shift <= tx_shift_nx;
         tx_bit   <= tx_bit_nx;
         uart_tx  <= tx_line_nx;
      end
   end

   // NOTE: every variable driven here gets a default first, so no latches are inferred.
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_div_nx   = tx_div;
      tx_shift_nx = tx_shift;
      tx_bit_nx   = tx_bit;
      tx_line_nx  = uart_tx;
      case (tx_state)
         TX_IDLE: begin
            tx_line_nx = 1'b1;
            if (!tx_empty) begin
               tx_state_nx = TX_START;
               tx_div_nx   = baud;
               tx_shift_nx = tx_mem[tx_rd_ptr];
               tx_cnt_nx   = '0;
               tx_line_nx  = 1'b0;
            end
         end
         TX_START: begin
            if (tx_last) begin
               tx_state_nx = TX_DATA;
               tx_cnt_nx   = '0;
               tx_bit_nx   = '0;
               tx_line_nx  = tx_shift[0];
            end else begin
               tx_cnt_nx = tx_cnt + 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_last) begin
               tx_cnt_nx = '0;
               if (tx_bit == 3'd7) begin
                  tx_state_nx = TX_STOP;
                  tx_line_nx  = 1'b1;
               end else begin
                  tx_bit_nx   = tx_bit + 3'd1;
                  tx_shift_nx = {1'b0, tx_shift[7:1]};
                  tx_line_nx  = tx_shift[1];
               end
            end else begin
               tx_cnt_nx = tx_cnt + 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_last) tx_state_nx = TX_IDLE;
            else         tx_cnt_nx   = tx_cnt + 16'd1;
         end
         default: tx_state_nx = TX_IDLE;
      endcase
   end

   // ---------------- RX FSM ----------------
   logic [1:0]  rx_sync;
   logic        rx_s;
   rx_state_t   rx_state, rx_state_nx;
   logic [15:0] rx_cnt, rx_cnt_nx, rx_div, rx_div_nx, rx_half;
   logic [7:0]  rx_shift, rx_shift_nx;
   logic [2:0]  rx_bit, rx_bit_nx;
   logic        rx_last, rx_done, rx_frame_bad;

   assign rx_s    = rx_sync[1];
   assign rx_last = (rx_cnt == rx_div - 16'd1);
   assign rx_half = {1'b0, rx_div[15:1]} - 16'd1;

   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         rx_sync  <= 2'b11;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= 16'(DIV_RESET);
         rx_shift <= '0;
         rx_bit   <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], uart_rx};
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_div   <= rx_div_nx;
         rx_shift <= rx_shift_nx;
         rx_bit   <= rx_bit_nx;
      end
   end

   always_comb begin
      rx_state_nx  = rx_state;
      rx_cnt_nx    = rx_cnt;
      rx_div_nx    = rx_div;
      rx_shift_nx  = rx_shift;
      rx_bit_nx    = rx_bit;
      rx_done      = 1'b0;
      rx_frame_bad = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_state_nx = RX_START;
               rx_div_nx   = baud;
               rx_cnt_nx   = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit recheck rejects glitches shorter than half a bit.
            if (rx_cnt == rx_half) begin
               rx_cnt_nx   = '0;
               rx_bit_nx   = '0;
               rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_nx = rx_cnt + 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_last) begin
               rx_cnt_nx   = '0;
               rx_shift_nx = {rx_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
               else                rx_bit_nx   = rx_bit + 3'd1;
            end else begin
               rx_cnt_nx = rx_cnt + 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_last) begin
               rx_cnt_nx = '0;
               if (rx_s) begin
                  rx_done     = 1'b1;
                  rx_state_nx = RX_IDLE;
               end else begin
                  rx_frame_bad = 1'b1;
                  rx_state_nx  = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_nx = rx_cnt + 16'd1;
            end
         end
         RX_WAIT_HIGH: if (rx_s) rx_state_nx = RX_IDLE;
         default: rx_state_nx = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0] rx_count;
   logic          rx_full, rx_empty, rx_push, rx_pop;

   assign rx_full  = (rx_count == FULL_CNT);
   assign rx_empty = (rx_count == '0);
   assign rx_push  = rx_done && !rx_full;
   assign rx_pop   = rx_pop_req && !rx_empty;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift_nx;
   end

   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      end
   end

   // ---------------- Registers and read port ----------------
   always_ff @(posedge clk or posedge resetq) begin
      if (resetq) begin
         baud         <= 16'(DIV_RESET);
         tx_overflow  <= 1'b0;
         rx_overflow  <= 1'b0;
         frame_err    <= 1'b0;
         io_read_data <= '0;
      end else begin
         if (io_write_enable && sel_baud)
            baud <= (io_write_data < 16'd4) ? 16'd4 : io_write_data;
         // A set arriving with the clearing read wins, so no event is lost.
         tx_overflow <= (tx_overflow && !status_rd) || (tx_push_req && tx_full);
         rx_overflow <= (rx_overflow && !status_rd) || (rx_done && rx_full);
         frame_err   <= (frame_err && !status_rd) || rx_frame_bad;
         if (io_read_enable) begin
            if (sel_data)
               io_read_data <= rx_empty ? 16'h0000 : {1'b1, 7'b0, rx_mem[rx_rd_ptr]};
            else if (sel_status)
               io_read_data <= {10'b0, tx_overflow, frame_err, rx_overflow,
                                rx_empty, tx_idle, tx_full};
            else if (sel_baud)
               io_read_data <= baud;
            else
               io_read_data <= 16'h0000;
         end
      end
   end

endmodule
